vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 119 +++++++++++
 tb/tb_vram_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// VRAM arbiter: owns a 64 x 2-bit map and serves one access per cycle to either the
// display scanner or the game logic. The game port gets a forced grant after a run of
// lost conflicts, and a clear request wipes the map one cell per cycle.
module vram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       disp_req,
  input  logic [5:0] disp_addr,
  output logic [1:0] disp_data,
  output logic       disp_valid,
  input  logic       game_req,
  input  logic       game_we,
  input  logic [5:0] game_addr,
  input  logic [1:0] game_wdata,
  output logic       game_ack,
  output logic [1:0] game_rdata,
  input  logic       clear_req,
  output logic       busy
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StServe, StClear} state_e;

  state_e           state_q, state_d;
  logic [5:0]       clr_cnt_q, clr_cnt_d;
  logic [3:0]       starve_q, starve_d;
  logic [63:0][1:0] mem_q, mem_d;
  logic             disp_valid_q, disp_valid_d;
  logic [1:0]       disp_data_q, disp_data_d;
  logic             game_ack_q, game_ack_d;
  logic [1:0]       game_rdata_q, game_rdata_d;
  logic             grant_disp, grant_game;

  // Arbitration, starvation tracking, clear sequencing and the map write port.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    starve_d   = starve_q;
    mem_d      = mem_q;
    grant_disp = 1'b0;
    grant_game = 1'b0;
    unique case (state_q)
      StServe: begin
        if (clear_req) begin
          // Clear outranks both requesters; no grant this cycle.
          state_d   = StClear;
          clr_cnt_d = '0;
        end else begin
          grant_disp = disp_req & ~(game_req & (starve_q == Limit));
          grant_game = game_req & ~grant_disp;
          if (game_req && grant_disp) begin
            if (starve_q < Limit) begin
              starve_d = starve_q + 4'd1;
            end
          end else begin
            starve_d = '0;
          end
        end
      end
      StClear: begin
        mem_d[clr_cnt_q] = 2'b00;
        clr_cnt_d        = clr_cnt_q + 6'd1;
        if (clr_cnt_q == 6'd63) begin
          state_d = StServe;
        end
      end
    endcase
    if (grant_game && game_we) begin
      mem_d[game_addr] = game_wdata;
    end
  end

  // Read data is captured at the grant edge; the data outputs hold between pulses.
  always_comb begin
    disp_valid_d = grant_disp;
    game_ack_d   = grant_game;
    disp_data_d  = disp_data_q;
    game_rdata_d = game_rdata_q;
    if (grant_disp) begin
      disp_data_d = mem_q[disp_addr];
    end
    if (grant_game && !game_we) begin
      game_rdata_d = mem_q[game_addr];
    end
  end

  // State, map and output registers; reset wipes the whole map at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StServe;
      clr_cnt_q    <= '0;
      starve_q     <= '0;
      mem_q        <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      game_ack_q   <= 1'b0;
      game_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      starve_q     <= starve_d;
      mem_q        <= mem_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      game_ack_q   <= game_ack_d;
      game_rdata_q <= game_rdata_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign game_ack   = game_ack_q;
  assign game_rdata = game_rdata_q;
  assign busy       = (state_q == StClear);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a randomized run checked against a
// cycle-level behavioural model of the map, arbitration rule and clear sequence.
module tb_vram_arbiter;

  localparam int SL = 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic       disp_req;
  logic [5:0] disp_addr;
  logic [1:0] disp_data;
  logic       disp_valid;
  logic       game_req;
  logic       game_we;
  logic [5:0] game_addr;
  logic [1:0] game_wdata;
  logic       game_ack;
  logic [1:0] game_rdata;
  logic       clear_req;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic [1:0] mem_m [64];
  int         starve_m;
  int         clear_left;
  logic       exp_dv, exp_ga, exp_busy;
  logic [1:0] exp_dd, exp_gr;

  vram_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .game_req   (game_req),
    .game_we    (game_we),
    .game_addr  (game_addr),
    .game_wdata (game_wdata),
    .game_ack   (game_ack),
    .game_rdata (game_rdata),
    .clear_req  (clear_req),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem_m[i] = 2'b00;
    starve_m   = 0;
    clear_left = 0;
    exp_dv     = 1'b0;
    exp_ga     = 1'b0;
    exp_busy   = 1'b0;
    exp_dd     = 2'b00;
    exp_gr     = 2'b00;
  endtask

  // Predict what the coming rising edge does, given the inputs currently applied.
  task automatic model_edge();
    logic gd, gg;
    gd = 1'b0;
    gg = 1'b0;
    if (!nrst) begin
      model_reset();
      return;
    end
    if (clear_left > 0) begin
      mem_m[64 - clear_left] = 2'b00;
      clear_left--;
    end else if (clear_req) begin
      clear_left = 64;
    end else begin
      // Game wins a conflict only after SL consecutive lost conflicts.
      gg = game_req && (!disp_req || starve_m == SL);
      gd = disp_req && !gg;
      if (gd) exp_dd = mem_m[disp_addr];
      if (gg) begin
        if (game_we) mem_m[game_addr] = game_wdata;
        else exp_gr = mem_m[game_addr];
      end
      if (game_req && gd) starve_m = (starve_m < SL) ? starve_m + 1 : starve_m;
      else starve_m = 0;
    end
    exp_dv   = gd;
    exp_ga   = gg;
    exp_busy = (clear_left > 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [1:0] val);
    int misses;
    misses     = 0;
    disp_req   = 1'b0;
    game_req   = 1'b1;
    game_we    = 1'b1;
    game_wdata = val;
    for (int i = 0; i < 64; i++) begin
      game_addr = 6'(i);
      tick();
      if (game_ack !== 1'b1) misses++;
    end
    game_req = 1'b0;
    tests_run++;
    if (misses != 0) begin
      tests_failed++;
      $display("FAIL fill_acks: %0d missing acks, want 0", misses);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    disp_req = 1'b1;
    disp_addr = 6'd0;
    repeat (2) tick();
    tests_run++;
    if ({disp_data, disp_valid, game_ack, game_rdata, busy} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {disp_data, disp_valid, game_ack, game_rdata, busy});
    end
    #2 nrst = 1'b1;
    tick();
    tests_run++;
    if (disp_valid !== 1'b1 || disp_data !== 2'd0) begin
      tests_failed++;
      $display("FAIL first_grant_after_release: valid %b data %0d want 1/0",
               disp_valid, disp_data);
    end
    disp_req = 1'b0;
    tick();
    tests_run++;
    if (disp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_one_pulse: got %b want 0", disp_valid);
    end
  endtask

  task automatic test_write_read();
    game_req = 1'b1; game_we = 1'b1; game_addr = 6'd5; game_wdata = 2'd2;
    tick();
    tests_run++;
    if (game_ack !== 1'b1 || game_rdata !== 2'd0) begin
      tests_failed++;
      $display("FAIL wr5_ack: ack %b rdata %0d want 1/0", game_ack, game_rdata);
    end
    game_req = 1'b0; disp_req = 1'b1; disp_addr = 6'd5;
    tick();
    tests_run++;
    if (disp_valid !== 1'b1 || disp_data !== 2'd2 || game_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd5_disp: valid %b data %0d ack %b want 1/2/0",
               disp_valid, disp_data, game_ack);
    end
    disp_req = 1'b0;
    tick();
    tests_run++;
    if (disp_valid !== 1'b0 || disp_data !== 2'd2) begin
      tests_failed++;
      $display("FAIL disp_hold: valid %b data %0d want 0/2", disp_valid, disp_data);
    end
  endtask

  task automatic test_raw_63();
    game_req = 1'b1; game_we = 1'b1; game_addr = 6'd63; game_wdata = 2'd1;
    tick();
    game_we = 1'b0;
    tick();
    tests_run++;
    if (game_ack !== 1'b1 || game_rdata !== 2'd1) begin
      tests_failed++;
      $display("FAIL raw63: ack %b rdata %0d want 1/1", game_ack, game_rdata);
    end
    game_req = 1'b0;
    tick();
    tests_run++;
    if (game_ack !== 1'b0 || game_rdata !== 2'd1) begin
      tests_failed++;
      $display("FAIL game_hold: ack %b rdata %0d want 0/1", game_ack, game_rdata);
    end
  endtask

  task automatic test_starvation();
    int misses;
    logic want_g;
    misses = 0;
    // Game alone: acked every cycle back-to-back.
    game_req = 1'b1; game_we = 1'b0; game_addr = 6'd5;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (game_ack !== 1'b1 || game_rdata !== 2'd2) misses++;
    end
    tests_run++;
    if (misses != 0) begin
      tests_failed++;
      $display("FAIL game_only_acks: %0d bad cycles want 0", misses);
    end
    // Both held: D,D,D,D,G repeating from a zero starve count.
    disp_req = 1'b1; disp_addr = 6'd63;
    for (int k = 1; k <= 20; k++) begin
      tick();
      want_g = (k % 5 == 0);
      tests_run++;
      if (game_ack !== want_g || disp_valid !== !want_g) begin
        tests_failed++;
        $display("FAIL starve_pattern[%0d]: disp %b game %b want %b/%b",
                 k, disp_valid, game_ack, !want_g, want_g);
      end
      tests_run++;
      if (disp_data !== 2'd1 || game_rdata !== 2'd2) begin
        tests_failed++;
        $display("FAIL starve_data[%0d]: disp %0d game %0d want 1/2", k, disp_data, game_rdata);
      end
    end
    disp_req = 1'b0; game_req = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    int n, bad;
    fill(2'd3);
    disp_req = 1'b1; disp_addr = 6'd7;
    game_req = 1'b1; game_we = 1'b0; game_addr = 6'd9;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tests_run++;
    if (disp_valid !== 1'b0 || game_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_cycle_grant: disp %b game %b want 0/0", disp_valid, game_ack);
    end
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 80) begin
      n++;
      if (disp_valid !== 1'b0 || game_ack !== 1'b0) bad++;
      tick();
    end
    tests_run++;
    if (n != 64) begin
      tests_failed++;
      $display("FAIL busy_length: got %0d cycles want 64", n);
    end
    tests_run++;
    if (bad != 0 || disp_valid !== 1'b0 || game_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL acks_during_clear: got %0d want 0", bad);
    end
    tick();
    tests_run++;
    if (disp_valid !== 1'b1 || disp_data !== 2'd0) begin
      tests_failed++;
      $display("FAIL resume_after_clear: valid %b data %0d want 1/0", disp_valid, disp_data);
    end
    disp_req = 1'b0; game_req = 1'b0;
    repeat (2) tick();
    bad = 0;
    disp_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      disp_addr = 6'(i);
      tick();
      if (disp_valid !== 1'b1 || disp_data !== 2'd0) bad++;
    end
    disp_req = 1'b0;
    tick();
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL readback_after_clear: %0d bad cells want 0", bad);
    end
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    fill(2'd3);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (20) tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_before_abort: got %b want 1", busy);
    end
    #2 nrst = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({disp_data, disp_valid, game_ack, game_rdata, busy} !== 7'b0) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: got %b want 0000000",
               {disp_data, disp_valid, game_ack, game_rdata, busy});
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || disp_valid !== 1'b0 || game_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL residual_after_abort: busy %b valid %b ack %b want 0/0/0",
               busy, disp_valid, game_ack);
    end
    bad = 0;
    game_req = 1'b1; game_we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      game_addr = 6'(i);
      tick();
      if (game_ack !== 1'b1 || game_rdata !== 2'd0) bad++;
    end
    game_req = 1'b0;
    tick();
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL readback_after_abort: %0d bad cells want 0", bad);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!disp_req && $urandom_range(0, 2) != 0) begin
        disp_req  = 1'b1;
        disp_addr = 6'($urandom_range(0, 15));
      end
      if (!game_req && $urandom_range(0, 2) != 0) begin
        game_req   = 1'b1;
        game_we    = 1'($urandom_range(0, 1));
        game_addr  = 6'($urandom_range(0, 15));
        game_wdata = 2'($urandom_range(0, 3));
      end
      clear_req = ($urandom_range(0, 149) == 0);
      tick();
      clear_req = 1'b0;
      tests_run++;
      if ({disp_valid, game_ack, busy, disp_data, game_rdata} !==
          {exp_dv, exp_ga, exp_busy, exp_dd, exp_gr}) begin
        tests_failed++;
        $display("FAIL random[%0d]: v/a/b/dd/gr got %b %b %b %0d %0d want %b %b %b %0d %0d",
                 c, disp_valid, game_ack, busy, disp_data, game_rdata,
                 exp_dv, exp_ga, exp_busy, exp_dd, exp_gr);
      end
      // A requester seeing its pulse may issue a fresh request or go idle.
      if (exp_dv) begin
        disp_req  = 1'($urandom_range(0, 1));
        disp_addr = 6'($urandom_range(0, 15));
      end
      if (exp_ga) begin
        game_req   = 1'($urandom_range(0, 1));
        game_we    = 1'($urandom_range(0, 1));
        game_addr  = 6'($urandom_range(0, 15));
        game_wdata = 2'($urandom_range(0, 3));
      end
    end
    disp_req = 1'b0; game_req = 1'b0;
    tick();
  endtask

  initial begin
    nrst = 1'b0;
    disp_req = 1'b0; disp_addr = '0;
    game_req = 1'b0; game_we = 1'b0; game_addr = '0; game_wdata = '0;
    clear_req = 1'b0;
    model_reset();
    test_reset();
    test_write_read();
    test_raw_63();
    test_starvation();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
